// File: rtl/stream_req_responder.sv
// Stream-request responder: descriptor table plus two independent read/stream engines (filter, input).
// Optional STREAM_STALL_CNT_EN adds per-channel stall-cycle counters (f_stall_cnt, i_stall_cnt).

module stream_req_channel #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] desc_base,
  input  logic [LEN_W-1:0]  desc_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              s_valid,
  output logic [DATA_W-1:0] s_data,
  output logic              s_last,
  input  logic              s_ready,
  output logic              finish
`ifdef STREAM_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE, RELEASE} state_t;
  state_t state_reg, state_next;

  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  len_reg, rd_cnt_reg, tx_cnt_reg;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr_reg, rd_ptr_reg, inflight_reg;
  logic [1:0]        occ_reg;
  logic              accept, push, pop;

  assign accept  = (state_reg == IDLE) && req_valid;
  assign push    = inflight_reg;
  assign s_valid = (state_reg == STREAM) && (occ_reg != 2'd0);
  assign pop     = s_valid && s_ready;
  assign s_data  = s_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign s_last  = s_valid && (tx_cnt_reg == len_reg - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = (desc_len == '0) ? DONE : STREAM;
      STREAM:  if (pop && s_last) state_next = DONE;
      DONE:    state_next = RELEASE;
      RELEASE: if (!req_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A slot freed by this cycle's pop may be refilled immediately, which keeps 1 beat/cycle.
  always_comb begin
    mem_rd_en = (state_reg == STREAM) && (rd_cnt_reg < len_reg) &&
                (((3'(occ_reg) + 3'(inflight_reg)) < 3'd2) || pop);
    mem_addr  = mem_rd_en ? base_reg + ADDR_W'(rd_cnt_reg) : '0;
    finish    = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg     <= '0;
      len_reg      <= '0;
      rd_cnt_reg   <= '0;
      tx_cnt_reg   <= '0;
      occ_reg      <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= mem_rd_en;
      if (accept) begin
        base_reg   <= desc_base;
        len_reg    <= desc_len;
        rd_cnt_reg <= '0;
        tx_cnt_reg <= '0;
        occ_reg    <= '0;
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
      end else begin
        if (mem_rd_en) rd_cnt_reg <= rd_cnt_reg + LEN_W'(1);
        if (push)      wr_ptr_reg <= ~wr_ptr_reg;
        if (pop) begin
          rd_ptr_reg <= ~rd_ptr_reg;
          tx_cnt_reg <= tx_cnt_reg + LEN_W'(1);
        end
        case ({push, pop})
          2'b10:   occ_reg <= occ_reg + 2'd1;
          2'b01:   occ_reg <= occ_reg - 2'd1;
          default: occ_reg <= occ_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_rdata;
  end

`ifdef STREAM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || (accept && desc_len != '0)) stall_cnt <= '0;
    else if (s_valid && !s_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

module stream_req_responder #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int LEN_W     = 10,
  parameter int NUM_LAYER = 4,
  parameter int MAX_K     = 64,
  localparam int LY_W     = $clog2(NUM_LAYER),
  localparam int K_W      = $clog2(MAX_K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_f_valid,
  input  logic [K_W-1:0]    req_f_k,
  input  logic [LY_W-1:0]   req_layer,
  input  logic              req_i_valid,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [LY_W-1:0]   cfg_layer,
  input  logic [K_W-1:0]    cfg_k,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              wmem_rd_en,
  output logic [ADDR_W-1:0] wmem_addr,
  input  logic [DATA_W-1:0] wmem_rdata,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  output logic              f_last,
  input  logic              f_ready,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  output logic              i_last,
  input  logic              i_ready,
  output logic              filter_finish,
  output logic              input_finish
`ifdef STREAM_STALL_CNT_EN
  ,
  output logic [15:0]       f_stall_cnt,
  output logic [15:0]       i_stall_cnt
`endif
);

  // Descriptor tables survive reset; only cfg_we writes them.
  logic [ADDR_W-1:0] f_base_mem [NUM_LAYER*MAX_K];
  logic [LEN_W-1:0]  f_len_mem  [NUM_LAYER*MAX_K];
  logic [ADDR_W-1:0] i_base_mem [NUM_LAYER];
  logic [LEN_W-1:0]  i_len_mem  [NUM_LAYER];

  always_ff @(posedge clk) begin
    if (cfg_we) begin
      if (!cfg_sel) begin
        f_base_mem[{cfg_layer, cfg_k}] <= cfg_base;
        f_len_mem[{cfg_layer, cfg_k}]  <= cfg_len;
      end else begin
        i_base_mem[cfg_layer] <= cfg_base;
        i_len_mem[cfg_layer]  <= cfg_len;
      end
    end
  end

  // Channel 0 = filter, channel 1 = input.
  logic [1:0]        ch_req, ch_rd_en, ch_valid, ch_last, ch_ready, ch_finish;
  logic [ADDR_W-1:0] ch_base [2];
  logic [ADDR_W-1:0] ch_addr [2];
  logic [LEN_W-1:0]  ch_len [2];
  logic [DATA_W-1:0] ch_rdata [2];
  logic [DATA_W-1:0] ch_data [2];
`ifdef STREAM_STALL_CNT_EN
  logic [15:0]       ch_stall [2];
`endif

  assign ch_req      = {req_i_valid, req_f_valid};
  assign ch_ready    = {i_ready, f_ready};
  assign ch_base[0]  = f_base_mem[{req_layer, req_f_k}];
  assign ch_len[0]   = f_len_mem[{req_layer, req_f_k}];
  assign ch_base[1]  = i_base_mem[req_layer];
  assign ch_len[1]   = i_len_mem[req_layer];
  assign ch_rdata[0] = wmem_rdata;
  assign ch_rdata[1] = imem_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      stream_req_channel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_chan (
        .clk       (clk),
        .rst       (rst),
        .req_valid (ch_req[gi]),
        .desc_base (ch_base[gi]),
        .desc_len  (ch_len[gi]),
        .mem_rd_en (ch_rd_en[gi]),
        .mem_addr  (ch_addr[gi]),
        .mem_rdata (ch_rdata[gi]),
        .s_valid   (ch_valid[gi]),
        .s_data    (ch_data[gi]),
        .s_last    (ch_last[gi]),
        .s_ready   (ch_ready[gi]),
        .finish    (ch_finish[gi])
`ifdef STREAM_STALL_CNT_EN
        ,
        .stall_cnt (ch_stall[gi])
`endif
      );
    end
  endgenerate

  assign wmem_rd_en    = ch_rd_en[0];
  assign wmem_addr     = ch_addr[0];
  assign imem_rd_en    = ch_rd_en[1];
  assign imem_addr     = ch_addr[1];
  assign f_valid       = ch_valid[0];
  assign f_data        = ch_data[0];
  assign f_last        = ch_last[0];
  assign i_valid       = ch_valid[1];
  assign i_data        = ch_data[1];
  assign i_last        = ch_last[1];
  assign filter_finish = ch_finish[0];
  assign input_finish  = ch_finish[1];
`ifdef STREAM_STALL_CNT_EN
  assign f_stall_cnt   = ch_stall[0];
  assign i_stall_cnt   = ch_stall[1];
`endif

endmodule

// File: tb/tb_stream_req_responder.sv
// Directed bench for stream_req_responder: buffer models return a tag|address word, a negedge monitor
// checks every presented beat against the expected address sequence and records timing.

module tb_stream_req_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_f_valid, req_i_valid, cfg_we, cfg_sel;
  logic [5:0]  req_f_k, cfg_k;
  logic [1:0]  req_layer, cfg_layer;
  logic [11:0] cfg_base;
  logic [9:0]  cfg_len;
  logic        wmem_rd_en, imem_rd_en;
  logic [11:0] wmem_addr, imem_addr;
  logic [31:0] wmem_rdata, imem_rdata;
  logic        f_valid, f_last, f_ready, i_valid, i_last, i_ready;
  logic [31:0] f_data, i_data;
  logic        filter_finish, input_finish;
`ifdef STREAM_STALL_CNT_EN
  logic [15:0] f_stall_cnt, i_stall_cnt;
`endif

  stream_req_responder dut (
    .clk(clk), .rst(rst),
    .req_f_valid(req_f_valid), .req_f_k(req_f_k), .req_layer(req_layer), .req_i_valid(req_i_valid),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_layer(cfg_layer), .cfg_k(cfg_k),
    .cfg_base(cfg_base), .cfg_len(cfg_len),
    .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .f_valid(f_valid), .f_data(f_data), .f_last(f_last), .f_ready(f_ready),
    .i_valid(i_valid), .i_data(i_data), .i_last(i_last), .i_ready(i_ready),
    .filter_finish(filter_finish), .input_finish(input_finish)
`ifdef STREAM_STALL_CNT_EN
    , .f_stall_cnt(f_stall_cnt), .i_stall_cnt(i_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer models: one-cycle read latency, word = tag | address.
  always @(posedge clk) begin
    if (wmem_rd_en) wmem_rdata <= 32'hA000_0000 | {20'h0, wmem_addr};
    if (imem_rd_en) imem_rdata <= 32'hB000_0000 | {20'h0, imem_addr};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Recorders filled by the monitor.
  logic [31:0] f_q[$], i_q[$];
  int          f_cq[$], i_cq[$];
  logic        f_lq[$], i_lq[$];
  int f_fin_cnt, i_fin_cnt, f_fin_cyc, i_fin_cyc, w_rd_n, ir_rd_n, w_first;
  logic [11:0] f_exp_base, i_exp_base;
  int          f_exp_len, i_exp_len;
  logic        f_fin_prev = 1'b0, i_fin_prev = 1'b0;

  task automatic clear_rec();
    f_q.delete(); i_q.delete(); f_cq.delete(); i_cq.delete(); f_lq.delete(); i_lq.delete();
    f_fin_cnt = 0; i_fin_cnt = 0; f_fin_cyc = -1; i_fin_cyc = -1;
    w_rd_n = 0; ir_rd_n = 0; w_first = -1;
  endtask

  always @(negedge clk) begin
    if (f_valid) begin
      check_eq("f_data", f_data, 32'hA000_0000 | {20'h0, f_exp_base + 12'(f_q.size())});
      check_eq("f_last", f_last, f_q.size() == f_exp_len - 1);
      if (f_ready) begin f_q.push_back(f_data); f_lq.push_back(f_last); f_cq.push_back(cyc); end
    end
    if (i_valid) begin
      check_eq("i_data", i_data, 32'hB000_0000 | {20'h0, i_exp_base + 12'(i_q.size())});
      check_eq("i_last", i_last, i_q.size() == i_exp_len - 1);
      if (i_ready) begin i_q.push_back(i_data); i_lq.push_back(i_last); i_cq.push_back(cyc); end
    end
    if (wmem_rd_en) begin w_rd_n++; if (w_first < 0) w_first = cyc; end
    if (imem_rd_en) ir_rd_n++;
    if (filter_finish) begin f_fin_cnt++; f_fin_cyc = cyc; check_eq("f_fin_pulse", f_fin_prev, 0); end
    if (input_finish)  begin i_fin_cnt++; i_fin_cyc = cyc; check_eq("i_fin_pulse", i_fin_prev, 0); end
    f_fin_prev = filter_finish;
    i_fin_prev = input_finish;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [1:0] ly, input logic [5:0] k,
                           input logic [11:0] base, input logic [9:0] len);
    cfg_we = 1'b1; cfg_sel = sel; cfg_layer = ly; cfg_k = k; cfg_base = base; cfg_len = len;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_fin(input string tag, input int f_target, input int i_target, input int budget);
    int c;
    c = 0;
    while ((f_fin_cnt < f_target || i_fin_cnt < i_target) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) check_eq(tag, 0, 1);
  endtask

  int n;

  initial begin
    rst = 1'b1; req_f_valid = 0; req_i_valid = 0; req_f_k = 0; req_layer = 0;
    cfg_we = 0; cfg_sel = 0; cfg_layer = 0; cfg_k = 0; cfg_base = 0; cfg_len = 0;
    f_ready = 0; i_ready = 0; f_exp_base = 0; i_exp_base = 0; f_exp_len = 0; i_exp_len = 0;
    clear_rec();
    repeat (3) step();
    check_eq("rst_f_valid", f_valid, 0);
    check_eq("rst_i_valid", i_valid, 0);
    check_eq("rst_wmem_rd", wmem_rd_en, 0);
    check_eq("rst_imem_rd", imem_rd_en, 0);
    check_eq("rst_f_data", f_data, 0);
    check_eq("rst_finish", {filter_finish, input_finish}, 0);
    rst = 1'b0;

    cfg_write(0, 2'd0, 6'd3, 12'h100, 10'd4);
    cfg_write(0, 2'd1, 6'd5, 12'h200, 10'd0);
    cfg_write(0, 2'd2, 6'd7, 12'h300, 10'd6);
    cfg_write(0, 2'd3, 6'd1, 12'hFFE, 10'd5);
    cfg_write(1, 2'd3, 6'd0, 12'h050, 10'd3);
    cfg_write(1, 2'd1, 6'd0, 12'h080, 10'd8);
    step();

    // Basic 4-beat stream with exact latency, then held request.
    clear_rec(); f_exp_base = 12'h100; f_exp_len = 4; f_ready = 1;
    req_layer = 0; req_f_k = 3; req_f_valid = 1; n = cyc;
    wait_fin("t1_timeout", 1, 0, 40);
    check_eq("t1_beats", f_q.size(), 4);
    check_eq("t1_first_rd", w_first, n + 1);
    check_eq("t1_fin_cyc", f_fin_cyc, n + 7);
    if (f_q.size() == 4) begin
      check_eq("t1_beat0_cyc", f_cq[0], n + 3);
      check_eq("t1_beat3_cyc", f_cq[3], n + 6);
      check_eq("t1_data0", f_q[0], 32'hA000_0100);
      check_eq("t1_last3", f_lq[3], 1);
    end
    repeat (10) step();
    check_eq("t5_hold_fin", f_fin_cnt, 1);
    check_eq("t5_hold_rd", w_rd_n, 4);
    req_f_valid = 0;
    repeat (2) step();
    clear_rec();
    req_f_valid = 1;
    wait_fin("t5_timeout", 1, 0, 40);
    check_eq("t5_again_beats", f_q.size(), 4);
    req_f_valid = 0;
    repeat (3) step();

    // Zero-length descriptor.
    clear_rec(); f_exp_len = 0;
    req_layer = 1; req_f_k = 5; req_f_valid = 1; n = cyc;
    wait_fin("t2_timeout", 1, 0, 20);
    check_eq("t2_rd_cnt", w_rd_n, 0);
    check_eq("t2_beats", f_q.size(), 0);
    check_eq("t2_fin_cyc", f_fin_cyc, n + 1);
    req_f_valid = 0;
    repeat (3) step();

    // Toggling backpressure; the monitor checks each presented beat against its index.
    clear_rec(); f_exp_base = 12'h300; f_exp_len = 6; f_ready = 1;
    req_layer = 2; req_f_k = 7; req_f_valid = 1;
    for (int c = 0; c < 80 && f_fin_cnt == 0; c++) begin
      step();
      f_ready = ~f_ready;
    end
    check_eq("t3_fin", f_fin_cnt, 1);
    check_eq("t3_beats", f_q.size(), 6);
    check_eq("t3_rd_cnt", w_rd_n, 6);
    f_ready = 1; req_f_valid = 0;
    repeat (3) step();

    // Concurrent filter (len 5, address wrap) and input (len 3).
    clear_rec(); f_exp_base = 12'hFFE; f_exp_len = 5; i_exp_base = 12'h050; i_exp_len = 3;
    f_ready = 1; i_ready = 1;
    req_layer = 3; req_f_k = 1; req_f_valid = 1; req_i_valid = 1; n = cyc;
    wait_fin("t4_timeout", 1, 1, 40);
    check_eq("t4_i_fin_cyc", i_fin_cyc, n + 6);
    check_eq("t4_f_fin_cyc", f_fin_cyc, n + 8);
    check_eq("t4_f_beats", f_q.size(), 5);
    check_eq("t4_i_beats", i_q.size(), 3);
    if (f_q.size() == 5) check_eq("t4_wrap", f_q[2], 32'hA000_0000);
    req_f_valid = 0; req_i_valid = 0;
    repeat (3) step();

    // Reset after two of eight input beats, then restart from base.
    clear_rec(); i_exp_base = 12'h080; i_exp_len = 8; i_ready = 1;
    req_layer = 1; req_i_valid = 1; n = cyc;
    repeat (5) step();
    rst = 1; i_ready = 0; req_i_valid = 0;
    step();
    check_eq("t6_i_valid", i_valid, 0);
    check_eq("t6_i_data", i_data, 0);
    check_eq("t6_imem_rd", imem_rd_en, 0);
    check_eq("t6_finish", input_finish, 0);
    rst = 0;
    repeat (6) step();
    check_eq("t6_beats", i_q.size(), 2);
    check_eq("t6_no_fin", i_fin_cnt, 0);
    clear_rec(); i_ready = 1; req_i_valid = 1;
    wait_fin("t6_timeout", 0, 1, 40);
    check_eq("t6_restart_beats", i_q.size(), 8);
    if (i_q.size() == 8) check_eq("t6_restart_d0", i_q[0], 32'hB000_0080);
    req_i_valid = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
